// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer
// Control FSM for one weight-stationary tile operation on an NxN systolic
// array. The phases are weight load (N cycles), input feed (k_len cycles) and
// pipeline drain (LAT cycles), followed by a single DONE cycle. All strobes
// are registered.
//
// Ports:
//   clk, rstn     clock (rising edge) and async active-low reset
//   start, k_len  start request and vector count; both are sampled only in IDLE
//   abort         synchronous abort; it has priority over everything else
//   busy, done    command-side status; done is a one-cycle pulse
//   w_load_en, w_row     weight-row write strobe and row index
//   feed_en, feed_idx    input vector strobe and index to the skew buffers
//   drain_en             high while the array drains
//   out_valid, out_idx   result row strobe and index (feed delayed by LAT)
//
// state  | meaning
// IDLE   | waiting for start with a non-zero k_len
// LOAD_W | writing weight rows 0..N-1
// FEED   | presenting input vectors 0..k_len-1
// DRAIN  | LAT cycles for the last results to leave the array
// DONE   | one-cycle completion pulse
module sa_tile_sequencer #(
  parameter int N   = 4,
  parameter int KW  = 8,
  parameter int LAT = 2*N-1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 w_load_en,
  output logic [$clog2(N)-1:0] w_row,
  output logic                 feed_en,
  output logic [KW-1:0]        feed_idx,
  output logic                 drain_en,
  output logic                 out_valid,
  output logic [KW-1:0]        out_idx
);

  localparam int RW = $clog2(N);
  localparam int DW = $clog2(LAT);
  // Delay stages between the registered feed strobe and out_valid; the
  // out_valid register itself provides the final stage.
  localparam int PD = LAT-1;

  localparam logic [RW-1:0] ROW_LAST   = RW'(N-1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k_lat;
  logic [DW-1:0]   r_drain_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_w_load_en;
  logic [RW-1:0]   r_w_row;
  logic            r_feed_en;
  logic [KW-1:0]   r_feed_idx;
  logic            r_drain_en;
  logic            r_out_valid;
  logic [KW-1:0]   r_out_idx;
  logic [PD-1:0]   r_pipe_v;
  logic [KW-1:0]   r_pipe_idx [PD];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_k_lat     <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_load_en <= 1'b0;
      r_w_row     <= '0;
      r_feed_en   <= 1'b0;
      r_feed_idx  <= '0;
      r_drain_en  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_pipe_v    <= '0;
      for (int i = 0; i < PD; i++) r_pipe_idx[i] <= '0;
    end else if (abort) begin
      // Abort keeps the latched k_len and clears everything else, including
      // any results still in flight.
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_load_en <= 1'b0;
      r_w_row     <= '0;
      r_feed_en   <= 1'b0;
      r_feed_idx  <= '0;
      r_drain_en  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_pipe_v    <= '0;
      for (int i = 0; i < PD; i++) r_pipe_idx[i] <= '0;
    end else begin
      // feed_idx is zero whenever feed_en is low, so out_idx is also zero
      // whenever out_valid is low. No extra masking is needed.
      r_pipe_v      <= {r_pipe_v[PD-2:0], r_feed_en};
      r_pipe_idx[0] <= r_feed_idx;
      for (int i = 1; i < PD; i++) r_pipe_idx[i] <= r_pipe_idx[i-1];
      r_out_valid   <= r_pipe_v[PD-1];
      r_out_idx     <= r_pipe_idx[PD-1];

      case (r_state)
        S_IDLE: begin
          if (start && (k_len != '0)) begin
            r_state     <= S_LOAD_W;
            r_k_lat     <= k_len;
            r_busy      <= 1'b1;
            r_w_load_en <= 1'b1;
            r_w_row     <= '0;
          end
        end
        S_LOAD_W: begin
          if (r_w_row == ROW_LAST) begin
            r_state     <= S_FEED;
            r_w_load_en <= 1'b0;
            r_w_row     <= '0;
            r_feed_en   <= 1'b1;
            r_feed_idx  <= '0;
          end else begin
            r_w_row <= r_w_row + RW'(1);
          end
        end
        S_FEED: begin
          if (r_feed_idx == r_k_lat - KW'(1)) begin
            r_state     <= S_DRAIN;
            r_feed_en   <= 1'b0;
            r_feed_idx  <= '0;
            r_drain_en  <= 1'b1;
            r_drain_cnt <= '0;
          end else begin
            r_feed_idx <= r_feed_idx + KW'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state     <= S_DONE;
            r_drain_en  <= 1'b0;
            r_drain_cnt <= '0;
            r_done      <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign w_load_en = r_w_load_en;
  assign w_row     = r_w_row;
  assign feed_en   = r_feed_en;
  assign feed_idx  = r_feed_idx;
  assign drain_en  = r_drain_en;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;

endmodule
